// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module      : imem_pkg
// Description : Shared types and constants for the instruction-memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_pkg;

    localparam int IMEM_ADDR_WIDTH = 12;

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_e;

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream input, memory write port and core control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_loader_if
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH
) ();

    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  start;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  cpu_rst;
    logic                  done;
    logic                  error;
    logic [ADDR_WIDTH-2:0] word_count;

    // Host / byte source side
    modport master (
        output in_data, in_valid, start,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, error, word_count
    );

    // Loader side
    modport slave (
        input  in_data, in_valid, start,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, error, word_count
    );

endinterface

`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
// ============================================================================
// Module      : word_assembler
// Description : Packs little-endian bytes into 32-bit words, keeps running XOR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_assembler (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic [7:0]  byte_in,
    input  wire logic        accept,
    input  wire logic        clear,
    output logic [31:0]      word,
    output logic             word_valid,
    output logic [7:0]       csum,
    output logic             last_byte
);

    logic [1:0]  idx_q,   idx_d;
    logic [23:0] shift_q, shift_d;
    logic [31:0] word_q,  word_d;
    logic        valid_q, valid_d;
    logic [7:0]  xor_q,   xor_d;

    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        word_d  = word_q;
        valid_d = 1'b0;
        xor_d   = xor_q;
        if (clear) begin
            idx_d = 2'd0;
            xor_d = 8'd0;
        end else if (accept) begin
            xor_d = xor_q ^ byte_in;
            idx_d = idx_q + 2'd1;
            // The fourth byte goes straight into the output word, no extra cycle
            if (idx_q == 2'd3) begin
                word_d  = {byte_in, shift_q};
                valid_d = 1'b1;
            end else begin
                shift_d[8*idx_q +: 8] = byte_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= 2'd0;
            shift_q <= 24'd0;
            word_q  <= 32'd0;
            valid_q <= 1'b0;
            xor_q   <= 8'd0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            xor_q   <= xor_d;
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;
    assign csum       = xor_q;
    assign last_byte  = (idx_q == 2'd3);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Framed byte-stream boot loader for the instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter int MAX_WORDS  = (2 ** ADDR_WIDTH) / 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    imem_loader_if.slave  bus
);

    localparam int CW = ADDR_WIDTH - 1;

    state_e                state_q,      state_d;
    logic [7:0]            len_lo_q,     len_lo_d;
    logic [CW-1:0]         n_q,          n_d;
    logic [CW-1:0]         word_count_q, word_count_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
    logic                  cpu_rst_q,    cpu_rst_d;
    logic                  done_q,       done_d;
    logic                  error_q,      error_d;

    logic        in_ready;
    logic        accept;
    logic        asm_accept;
    logic        asm_clear;
    logic [15:0] len_full;
    logic [31:0] asm_word;
    logic        asm_valid;
    logic [7:0]  asm_csum;
    logic        asm_last;

    assign in_ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                      (state_q == DATA)   || (state_q == CSUM);
    assign accept   = bus.in_valid && in_ready;
    assign len_full = {bus.in_data, len_lo_q};

    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        n_d          = n_q;
        word_count_d = word_count_q;
        mem_addr_d   = mem_addr_q;
        cpu_rst_d    = cpu_rst_q;
        done_d       = done_q;
        error_d      = error_q;
        asm_accept   = 1'b0;
        asm_clear    = 1'b0;

        case (state_q)
            LEN_LO: begin
                if (accept) begin
                    len_lo_d = bus.in_data;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    n_d = len_full[CW-1:0];
                    if ({16'd0, len_full} > 32'(MAX_WORDS)) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    asm_accept = 1'b1;
                    // Address and count are registered alongside the write strobe
                    if (asm_last) begin
                        word_count_d = word_count_q + CW'(1);
                        mem_addr_d   = {word_count_q[ADDR_WIDTH-3:0], 2'b00};
                        if (word_count_q + CW'(1) == n_q) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    if (bus.in_data == asm_csum) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end
            end
            DONE, ERR: begin
                if (bus.start) begin
                    state_d      = LEN_LO;
                    cpu_rst_d    = 1'b1;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    word_count_d = '0;
                    mem_addr_d   = '0;
                    asm_clear    = 1'b1;
                end
            end
            default: begin
                state_d = LEN_LO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LEN_LO;
            len_lo_q     <= 8'd0;
            n_q          <= '0;
            word_count_q <= '0;
            mem_addr_q   <= '0;
            cpu_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            n_q          <= n_d;
            word_count_q <= word_count_d;
            mem_addr_q   <= mem_addr_d;
            cpu_rst_q    <= cpu_rst_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    word_assembler u_word_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (bus.in_data),
        .accept     (asm_accept),
        .clear      (asm_clear),
        .word       (asm_word),
        .word_valid (asm_valid),
        .csum       (asm_csum),
        .last_byte  (asm_last)
    );

    assign bus.in_ready   = in_ready;
    assign bus.mem_we     = asm_valid;
    assign bus.mem_wdata  = asm_word;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.cpu_rst    = cpu_rst_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.word_count = word_count_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench: frame table, corner sequences, random frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [54:0] wr_t;          // {addr[11:0], data[31:0], word_count[10:0]}
    typedef wr_t         wr_q_t[$];

    typedef struct {
        int           len;
        logic [127:0] bytes;            // stream order, first byte most significant
        bit           exp_done;
        bit           exp_err;
        int           exp_wc;
        int           exp_nwr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    imem_loader_if #(.ADDR_WIDTH(12)) bus ();

    imem_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    wr_q_t obs;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1)
            obs.push_back({bus.mem_addr, bus.mem_wdata, bus.word_count});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk the frame by its format rules.
    function automatic void model(input byte_q_t b, output wr_q_t w, output bit d,
                                  output bit e, output int wc);
        int n;
        logic [7:0]  x;
        logic [31:0] wd;
        w  = {};
        d  = 1'b0;
        e  = 1'b0;
        wc = 0;
        x  = 8'd0;
        n  = int'(b[0]) + 256 * int'(b[1]);
        if (n > 1024) begin
            e = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            wd = 32'd0;
            for (int j = 0; j < 4; j++) begin
                wd = wd | (32'(b[2 + 4*k + j]) << (8*j));
                x  = x ^ b[2 + 4*k + j];
            end
            w.push_back({12'(4*k), wd, 11'(k + 1)});
        end
        wc = n;
        if (b[2 + 4*n] == x) d = 1'b1;
        else                 e = 1'b1;
    endfunction

    function automatic byte_q_t make_frame(input int n, input bit good);
        byte_q_t    b;
        logic [7:0] x;
        logic [7:0] r;
        x = 8'd0;
        b.push_back(8'(n));
        b.push_back(8'(n >> 8));
        for (int k = 0; k < 4*n; k++) begin
            r = 8'($urandom);
            x = x ^ r;
            b.push_back(r);
        end
        b.push_back(good ? x : (x ^ 8'($urandom_range(255, 1))));
        return b;
    endfunction

    // Drives bytes until all accepted; returns at the negedge after the last accept.
    task automatic send(input byte_q_t b, input int gap_pct);
        int i;
        int cyc;
        bit acc;
        i   = 0;
        cyc = 0;
        while (i < b.size()) begin
            @(negedge clk);
            if ($urandom_range(99) < gap_pct) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = b[i];
            end
            acc = bus.in_valid && (bus.in_ready === 1'b1);
            @(posedge clk);
            if (acc) i++;
            cyc++;
            if (cyc > 10 * b.size() + 100) begin
                n_checks++;
                n_fail++;
                $display("FAIL send timeout: accepted %0d of %0d bytes", i, b.size());
                break;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h05;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        chk("start cpu_rst", bus.cpu_rst, 1);
        chk("start done", bus.done, 0);
        chk("start error", bus.error, 0);
        chk("start word_count", bus.word_count, 0);
        chk("start mem_addr", bus.mem_addr, 0);
        chk("start in_ready", bus.in_ready, 1);
        obs.delete();
    endtask

    task automatic check_model(input string name, input byte_q_t b);
        wr_q_t ew;
        bit    ed;
        bit    ee;
        int    ewc;
        model(b, ew, ed, ee, ewc);
        chk({name, " done"}, bus.done, 64'(ed));
        chk({name, " error"}, bus.error, 64'(ee));
        chk({name, " cpu_rst"}, bus.cpu_rst, 64'(!ed));
        chk({name, " in_ready"}, bus.in_ready, 0);
        chk({name, " word_count"}, bus.word_count, 64'(ewc));
        chk({name, " nwrites"}, obs.size(), ew.size());
        for (int k = 0; k < ew.size() && k < obs.size(); k++)
            chk($sformatf("%s write%0d", name, k), obs[k], ew[k]);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t    vec[6];
        byte_q_t b;
        byte_q_t part;

        vec[0] = '{11, 128'h0200_13005000_93051000_C5, 1'b1, 1'b0, 2, 2};
        vec[1] = '{11, 128'h0200_13005000_93051000_C4, 1'b0, 1'b1, 2, 2};
        vec[2] = '{2,  128'h0104,                      1'b0, 1'b1, 0, 0};
        vec[3] = '{3,  128'h0000_00,                   1'b1, 1'b0, 0, 0};
        vec[4] = '{7,  128'h0100_EFBEADDE_22,          1'b1, 1'b0, 1, 1};
        vec[5] = '{3,  128'h0000_01,                   1'b0, 1'b1, 0, 0};

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset cpu_rst", bus.cpu_rst, 1);
        chk("reset mem_we", bus.mem_we, 0);
        chk("reset mem_addr", bus.mem_addr, 0);
        chk("reset mem_wdata", bus.mem_wdata, 0);
        chk("reset done", bus.done, 0);
        chk("reset error", bus.error, 0);
        chk("reset word_count", bus.word_count, 0);
        chk("reset in_ready", bus.in_ready, 1);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if (i > 0) do_start();
            b = {};
            for (int k = 0; k < vec[i].len; k++)
                b.push_back(vec[i].bytes[8*(vec[i].len - 1 - k) +: 8]);
            send(b, 0);
            chk($sformatf("vec%0d done", i), bus.done, 64'(vec[i].exp_done));
            chk($sformatf("vec%0d error", i), bus.error, 64'(vec[i].exp_err));
            chk($sformatf("vec%0d word_count", i), bus.word_count, 64'(vec[i].exp_wc));
            chk($sformatf("vec%0d nwrites", i), obs.size(), 64'(vec[i].exp_nwr));
            check_model($sformatf("vec%0d", i), b);
            if (i == 0 && obs.size() == 2) begin
                chk("twoword w0", obs[0][54:11], {12'h000, 32'h00500013});
                chk("twoword w1", obs[1][54:11], {12'h004, 32'h00100593});
            end
        end

        // Backpressure: same two-word frame with random gaps
        do_start();
        b = {};
        for (int k = 0; k < vec[0].len; k++)
            b.push_back(vec[0].bytes[8*(vec[0].len - 1 - k) +: 8]);
        send(b, 50);
        check_model("gaps", b);

        // Asynchronous reset after five payload bytes
        do_start();
        part = {};
        for (int k = 0; k < 7; k++) part.push_back(b[k]);
        send(part, 0);
        chk("midload word_count before", bus.word_count, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midload mem_we", bus.mem_we, 0);
        chk("midload word_count", bus.word_count, 0);
        chk("midload mem_addr", bus.mem_addr, 0);
        chk("midload mem_wdata", bus.mem_wdata, 0);
        chk("midload cpu_rst", bus.cpu_rst, 1);
        chk("midload in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        obs.delete();
        send(b, 0);
        check_model("after_reset", b);

        for (int r = 0; r < 8; r++) begin
            do_start();
            b = make_frame($urandom_range(8), $urandom_range(3) != 0);
            send(b, 30);
            check_model($sformatf("rand%0d", r), b);
        end

        // Largest legal frame fills the whole address space
        do_start();
        b = make_frame(1024, 1'b1);
        send(b, 0);
        check_model("max_words", b);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
